// File: rtl/seq_divider_if.sv
// Start/busy/done handshake and operand/result bus between the ALU controller and seq_divider.
// SEQ_DIVIDER_SIGNED_EN adds the is_signed operand qualifier.
interface seq_divider_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
`ifdef SEQ_DIVIDER_SIGNED_EN
  logic             is_signed;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
`ifdef SEQ_DIVIDER_SIGNED_EN
    output is_signed,
`endif
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
`ifdef SEQ_DIVIDER_SIGNED_EN
    input  is_signed,
`endif
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider.sv
// Sequential restoring divider, one quotient bit per clock, start/busy/done handshake.
// Define SEQ_DIVIDER_SIGNED_EN for two's-complement operands (truncating division).
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  seq_divider_if.slave  bus
);
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t                r_state;
  state_t                w_next;
  logic [CNT_W-1:0]      r_cnt;
  logic                  w_accept;

  logic [WIDTH-1:0]      r_p;
  logic [WIDTH-1:0]      r_q;
  logic [WIDTH-1:0]      r_div;
  logic [WIDTH-1:0]      r_dvd_raw;
  logic                  r_zero;
  logic [WIDTH:0]        w_p_shift;
  logic signed [WIDTH:0] w_t;
  logic [WIDTH-1:0]      w_dvd_mag;
  logic [WIDTH-1:0]      w_dvs_mag;
  logic [WIDTH-1:0]      w_quo_fix;
  logic [WIDTH-1:0]      w_rem_fix;

  logic                  r_done;
  logic [WIDTH-1:0]      r_quo;
  logic [WIDTH-1:0]      r_rem;
  logic                  r_dbz;

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic                  r_neg_q;
  logic                  r_neg_r;

  function automatic logic [WIDTH-1:0] negate_if(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? ((~v) + WIDTH'(1)) : v;
  endfunction

  // |most-negative| still fits as an unsigned WIDTH-bit magnitude.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
    return negate_if(v, sgn & v[WIDTH-1]);
  endfunction

  assign w_dvd_mag = magnitude(bus.dividend, bus.is_signed);
  assign w_dvs_mag = magnitude(bus.divisor, bus.is_signed);
  assign w_quo_fix = negate_if(r_q, r_neg_q);
  assign w_rem_fix = negate_if(r_p, r_neg_r);
`else
  assign w_dvd_mag = bus.dividend;
  assign w_dvs_mag = bus.divisor;
  assign w_quo_fix = r_q;
  assign w_rem_fix = r_p;
`endif

  assign w_accept = (r_state == S_IDLE) && bus.start;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept)
        r_cnt <= CNT_W'(WIDTH - 1);
      else if (r_state == S_CALC)
        r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (bus.start) w_next = (bus.divisor == '0) ? S_DONE : S_CALC;
      S_CALC: if (r_cnt == '0) w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // P < 2*divisor, so T lies in [-divisor, divisor) and WIDTH+1 signed bits suffice.
  assign w_p_shift = {r_p, r_q[WIDTH-1]};
  assign w_t       = $signed(w_p_shift) - $signed({1'b0, r_div});

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_p       <= '0;
      r_q       <= w_dvd_mag;
      r_div     <= w_dvs_mag;
      r_dvd_raw <= bus.dividend;
      r_zero    <= (bus.divisor == '0);
`ifdef SEQ_DIVIDER_SIGNED_EN
      r_neg_q   <= bus.is_signed & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
      r_neg_r   <= bus.is_signed & bus.dividend[WIDTH-1];
`endif
    end else if (r_state == S_CALC) begin
      r_p <= w_t[WIDTH] ? w_p_shift[WIDTH-1:0] : w_t[WIDTH-1:0];
      r_q <= {r_q[WIDTH-2:0], ~w_t[WIDTH]};
    end
  end

  // Results are published only on leaving DONE and hold otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_done <= 1'b0;
      r_quo  <= '0;
      r_rem  <= '0;
      r_dbz  <= 1'b0;
    end else begin
      r_done <= (r_state == S_DONE);
      if (w_accept)
        r_dbz <= 1'b0;
      if (r_state == S_DONE) begin
        if (r_zero) begin
          r_quo <= '1;
          r_rem <= r_dvd_raw;
          r_dbz <= 1'b1;
        end else begin
          r_quo <= w_quo_fix;
          r_rem <= w_rem_fix;
          r_dbz <= 1'b0;
        end
      end
    end
  end

  assign bus.busy        = (r_state != S_IDLE);
  assign bus.done        = r_done;
  assign bus.quotient    = r_quo;
  assign bus.remainder   = r_rem;
  assign bus.div_by_zero = r_dbz;
endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider (WIDTH=8); signed cases need SEQ_DIVIDER_SIGNED_EN.
module tb_seq_divider;
  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  seq_divider_if #(.WIDTH(WIDTH)) bus();
  seq_divider #(.WIDTH(WIDTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;

  // Called at posedge+1 with the DUT idle (or in its done cycle). Returns edges from
  // accept to done (0 on timeout) and the number of samples where busy was low before done.
  task automatic issue(input logic [7:0] dvd, input logic [7:0] dvs,
                       output int lat, output int busy_low);
    bus.start    = 1'b1;
    bus.dividend = dvd;
    bus.divisor  = dvs;
    @(posedge clk); #1;
    bus.start    = 1'b0;
    bus.dividend = 8'($urandom);
    bus.divisor  = 8'($urandom);
    lat = 0;
    busy_low = 0;
    if (!bus.busy) busy_low++;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        lat = k;
        break;
      end
      if (!bus.busy) busy_low++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", bus.done); end
    n_cmp++; if (bus.quotient !== 8'h00) begin n_bad++; $display("FAIL reset_quo got %h want 00", bus.quotient); end
    n_cmp++; if (bus.remainder !== 8'h00) begin n_bad++; $display("FAIL reset_rem got %h want 00", bus.remainder); end
    n_cmp++; if (bus.div_by_zero !== 1'b0) begin n_bad++; $display("FAIL reset_dbz got %b want 0", bus.div_by_zero); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int lat, bl;
    issue(8'd200, 8'd7, lat, bl);
    n_cmp++; if (lat !== 9) begin n_bad++; $display("FAIL basic_latency got %0d want 9", lat); end
    n_cmp++; if (bl !== 0) begin n_bad++; $display("FAIL basic_busy_low got %0d want 0", bl); end
    n_cmp++; if (bus.quotient !== 8'd28) begin n_bad++; $display("FAIL basic_quo got %0d want 28", bus.quotient); end
    n_cmp++; if (bus.remainder !== 8'd4) begin n_bad++; $display("FAIL basic_rem got %0d want 4", bus.remainder); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL basic_busy_at_done got %b want 0", bus.busy); end
    @(posedge clk); #1;
    n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL basic_done_pulse got %b want 0", bus.done); end
  endtask

  task automatic test_edges();
    logic [7:0] vd [5] = '{8'hFF, 8'h05, 8'h2A, 8'h00, 8'h10};
    logic [7:0] vs [5] = '{8'h01, 8'h09, 8'h00, 8'h05, 8'h03};
    logic [7:0] eq [5] = '{8'hFF, 8'h00, 8'hFF, 8'h00, 8'h05};
    logic [7:0] er [5] = '{8'h00, 8'h05, 8'h2A, 8'h00, 8'h01};
    logic       ez [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    int         el [5] = '{9, 9, 1, 9, 9};
    int lat, bl;
    for (int i = 0; i < 5; i++) begin
      issue(vd[i], vs[i], lat, bl);
      n_cmp++;
      if (lat !== el[i] || bus.quotient !== eq[i] || bus.remainder !== er[i] || bus.div_by_zero !== ez[i]) begin
        n_bad++;
        $display("FAIL edge_%0d got lat=%0d q=%h r=%h z=%b want lat=%0d q=%h r=%h z=%b",
                 i, lat, bus.quotient, bus.remainder, bus.div_by_zero, el[i], eq[i], er[i], ez[i]);
      end
    end
  endtask

  task automatic test_hold_and_dbz_clear();
    int lat, bl;
    issue(8'h2A, 8'h00, lat, bl);
    bus.start = 1'b1; bus.dividend = 8'd50; bus.divisor = 8'd6;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (bus.div_by_zero !== 1'b0) begin n_bad++; $display("FAIL dbz_clear got %b want 0", bus.div_by_zero); end
    n_cmp++; if (bus.quotient !== 8'hFF || bus.remainder !== 8'h2A) begin
      n_bad++; $display("FAIL hold_in_calc got q=%h r=%h want q=ff r=2a", bus.quotient, bus.remainder);
    end
    for (int k = 0; k < 20 && !bus.done; k++) begin @(posedge clk); #1; end
    n_cmp++; if (bus.done !== 1'b1 || bus.quotient !== 8'd8 || bus.remainder !== 8'd2) begin
      n_bad++; $display("FAIL hold_result got done=%b q=%0d r=%0d want done=1 q=8 r=2", bus.done, bus.quotient, bus.remainder);
    end
  endtask

  task automatic test_ignore_start();
    int dones = 0;
    bus.start = 1'b1; bus.dividend = 8'd200; bus.divisor = 8'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    bus.start = 1'b1; bus.dividend = 8'd50; bus.divisor = 8'd5;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int k = 0; k < 25; k++) begin
      if (bus.done) begin
        dones++;
        n_cmp++; if (bus.quotient !== 8'd28 || bus.remainder !== 8'd4) begin
          n_bad++; $display("FAIL ignore_result got q=%0d r=%0d want q=28 r=4", bus.quotient, bus.remainder);
        end
      end
      @(posedge clk); #1;
    end
    n_cmp++; if (dones !== 1) begin n_bad++; $display("FAIL ignore_done_count got %0d want 1", dones); end
  endtask

  task automatic test_reset_mid();
    int dones = 0;
    int lat, bl;
    bus.start = 1'b1; bus.dividend = 8'd200; bus.divisor = 8'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.quotient !== 8'h00 ||
                 bus.remainder !== 8'h00 || bus.div_by_zero !== 1'b0) begin
      n_bad++; $display("FAIL midreset_outputs got busy=%b done=%b q=%h r=%h z=%b want all 0",
                        bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      if (bus.done) dones++;
    end
    n_cmp++; if (dones !== 0) begin n_bad++; $display("FAIL midreset_no_done got %0d want 0", dones); end
    issue(8'd100, 8'd10, lat, bl);
    n_cmp++; if (lat !== 9 || bus.quotient !== 8'd10 || bus.remainder !== 8'd0) begin
      n_bad++; $display("FAIL after_reset_div got lat=%0d q=%0d r=%0d want lat=9 q=10 r=0", lat, bus.quotient, bus.remainder);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] dvds [8] = '{8'd0, 8'd1, 8'd7, 8'd100, 8'd127, 8'd128, 8'd200, 8'd255};
    logic [7:0] dvs, exp_q, exp_r;
    int lat, bl, exp_lat, dones, extra;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 256; j += 5) begin
        dvs = 8'(j);
        if (dvs == 8'd0) begin
          exp_q = 8'hFF; exp_r = dvds[i]; exp_lat = 1;
        end else begin
          exp_q = dvds[i] / dvs; exp_r = dvds[i] % dvs; exp_lat = 9;
        end
        issue(dvds[i], dvs, lat, bl);
        if (lat != 0) dones++;
        n_cmp++;
        if (lat !== exp_lat || bus.quotient !== exp_q || bus.remainder !== exp_r) begin
          n_bad++;
          $display("FAIL b2b_%0d_%0d got lat=%0d q=%0d r=%0d want lat=%0d q=%0d r=%0d",
                   dvds[i], dvs, lat, bus.quotient, bus.remainder, exp_lat, exp_q, exp_r);
        end
        if (dvs != 8'd0) begin
          n_cmp++;
          if ((int'(bus.quotient) * int'(dvs) + int'(bus.remainder)) !== int'(dvds[i]) || bus.remainder >= dvs) begin
            n_bad++;
            $display("FAIL b2b_invariant_%0d_%0d got q=%0d r=%0d", dvds[i], dvs, bus.quotient, bus.remainder);
          end
        end
      end
    end
    extra = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (bus.done) extra++;
    end
    n_cmp++; if (dones !== 416 || extra !== 0) begin
      n_bad++; $display("FAIL b2b_done_count got %0d extra=%0d want 416 extra=0", dones, extra);
    end
  endtask

`ifdef SEQ_DIVIDER_SIGNED_EN
  task automatic test_signed();
    logic [7:0] vd [4] = '{8'hF9, 8'h07, 8'h80, 8'hF9};
    logic [7:0] vs [4] = '{8'h02, 8'hFE, 8'hFF, 8'h00};
    logic [7:0] eq [4] = '{8'hFD, 8'hFD, 8'h80, 8'hFF};
    logic [7:0] er [4] = '{8'hFF, 8'h01, 8'h00, 8'hF9};
    logic       ez [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    int         el [4] = '{9, 9, 9, 1};
    int lat, bl;
    bus.is_signed = 1'b1;
    for (int i = 0; i < 4; i++) begin
      issue(vd[i], vs[i], lat, bl);
      n_cmp++;
      if (lat !== el[i] || bus.quotient !== eq[i] || bus.remainder !== er[i] || bus.div_by_zero !== ez[i]) begin
        n_bad++;
        $display("FAIL signed_%0d got lat=%0d q=%h r=%h z=%b want lat=%0d q=%h r=%h z=%b",
                 i, lat, bus.quotient, bus.remainder, bus.div_by_zero, el[i], eq[i], er[i], ez[i]);
      end
    end
    bus.is_signed = 1'b0;
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
`ifdef SEQ_DIVIDER_SIGNED_EN
    bus.is_signed = 1'b0;
`endif
    rst_n = 1'b0;
    test_reset();
    test_basic();
    test_edges();
    test_hold_and_dbz_clear();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
`ifdef SEQ_DIVIDER_SIGNED_EN
    test_signed();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
